// File: rtl/cmd_exec_pipeline.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmd_exec_pipeline : UART command parser -> command FIFO -> register dispatcher
// Rev 1.0
// ---------------------------------------------------------------------------
module cmd_exec_pipeline #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_fifo_valid,
  input  logic [7:0] byte_fifo_data,
  output logic       byte_fifo_rd_en,
  output logic [7:0] mem_addr,
  output logic       mem_write_en,
  output logic [7:0] mem_write_data,
  output logic       mem_read_en,
  input  logic [7:0] mem_read_data,
  output logic [7:0] data_out_tx,
  output logic       out_tx_en,
  output logic       cmd_fifo_full,
  output logic       cmd_fifo_empty
);

  localparam logic [7:0] c_op_write = 8'h57;
  localparam logic [7:0] c_op_read  = 8'h52;

  typedef enum logic [1:0] {P_OP, P_ADDR, P_DATA, P_PUSH} parser_state_e;
  typedef enum logic [1:0] {D_IDLE, D_EXEC, D_READ_WAIT, D_RESP} disp_state_e;

  parser_state_e p_state_q, p_state_d;
  logic [7:0] op_q, op_d, addr_q, addr_d, data_q, data_d;

  logic [23:0]         fifo_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                fifo_wr_en, fifo_rd_en, rd_ok;
  logic [23:0]         head;

  disp_state_e d_state_q, d_state_d;
  logic [7:0] mem_addr_q, mem_addr_d, mem_write_data_q, mem_write_data_d;
  logic       mem_write_en_q, mem_write_en_d, mem_read_en_q, mem_read_en_d;
  logic [7:0] data_out_q, data_out_d;
  logic       out_tx_en_q, out_tx_en_d;

  // Gated by rst so no byte is popped while the parser is held in reset.
  assign byte_fifo_rd_en = rst && byte_fifo_valid && (p_state_q != P_PUSH);
  assign fifo_wr_en      = (p_state_q == P_PUSH) && !full_q;

  always_comb begin
    p_state_d = p_state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    case (p_state_q)
      P_OP: begin
        if (byte_fifo_rd_en &&
            (byte_fifo_data == c_op_write || byte_fifo_data == c_op_read)) begin
          op_d      = byte_fifo_data;
          p_state_d = P_ADDR;
        end
      end
      P_ADDR: begin
        if (byte_fifo_rd_en) begin
          addr_d = byte_fifo_data;
          if (op_q == c_op_write) begin
            p_state_d = P_DATA;
          end else begin
            data_d    = 8'h00;
            p_state_d = P_PUSH;
          end
        end
      end
      P_DATA: begin
        if (byte_fifo_rd_en) begin
          data_d    = byte_fifo_data;
          p_state_d = P_PUSH;
        end
      end
      P_PUSH: begin
        if (!full_q) p_state_d = P_OP;
      end
      default: p_state_d = P_OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_state_q <= P_OP;
      op_q      <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
    end else begin
      p_state_q <= p_state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // Command FIFO: show-ahead circular buffer, flags registered from next count.
  assign rd_ok = fifo_rd_en && !empty_q;
  assign head  = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = fifo_wr_en ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok      ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d  = count_q + (ADDR_WIDTH+1)'(fifo_wr_en) - (ADDR_WIDTH+1)'(rd_ok);
    full_d   = (count_d == (ADDR_WIDTH+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (fifo_wr_en) fifo_mem_q[wr_ptr_q] <= {op_q, addr_q, data_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Dispatcher: strobes are set on entry to EXEC so they are registered outputs.
  assign fifo_rd_en = (d_state_q == D_IDLE) && !empty_q;

  always_comb begin
    d_state_d        = d_state_q;
    mem_addr_d       = 8'h00;
    mem_write_en_d   = 1'b0;
    mem_write_data_d = 8'h00;
    mem_read_en_d    = 1'b0;
    data_out_d       = data_out_q;
    out_tx_en_d      = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        if (fifo_rd_en) begin
          mem_addr_d = head[15:8];
          if (head[23:16] == c_op_write) begin
            mem_write_en_d   = 1'b1;
            mem_write_data_d = head[7:0];
          end else begin
            mem_read_en_d = 1'b1;
          end
          d_state_d = D_EXEC;
        end
      end
      D_EXEC:      d_state_d = mem_read_en_q ? D_READ_WAIT : D_IDLE;
      D_READ_WAIT: begin
        data_out_d  = mem_read_data;
        out_tx_en_d = 1'b1;
        d_state_d   = D_RESP;
      end
      D_RESP:      d_state_d = D_IDLE;
      default:     d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_state_q        <= D_IDLE;
      mem_addr_q       <= 8'h00;
      mem_write_en_q   <= 1'b0;
      mem_write_data_q <= 8'h00;
      mem_read_en_q    <= 1'b0;
      data_out_q       <= 8'h00;
      out_tx_en_q      <= 1'b0;
    end else begin
      d_state_q        <= d_state_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_en_q    <= mem_read_en_d;
      data_out_q       <= data_out_d;
      out_tx_en_q      <= out_tx_en_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read_en    = mem_read_en_q;
  assign data_out_tx    = data_out_q;
  assign out_tx_en      = out_tx_en_q;
  assign cmd_fifo_full  = full_q;
  assign cmd_fifo_empty = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_exec_pipeline.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmd_exec_pipeline : directed self-checking bench for cmd_exec_pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cmd_exec_pipeline;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       byte_fifo_valid = 1'b0;
  logic [7:0] byte_fifo_data = 8'h00;
  logic [7:0] mem_read_data = 8'h00;
  logic       byte_fifo_rd_en, mem_write_en, mem_read_en, out_tx_en;
  logic       cmd_fifo_full, cmd_fifo_empty;
  logic [7:0] mem_addr, mem_write_data, data_out_tx;

  cmd_exec_pipeline #(.DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .byte_fifo_valid(byte_fifo_valid),
    .byte_fifo_data (byte_fifo_data),
    .byte_fifo_rd_en(byte_fifo_rd_en),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_en    (mem_read_en),
    .mem_read_data  (mem_read_data),
    .data_out_tx    (data_out_tx),
    .out_tx_en      (out_tx_en),
    .cmd_fifo_full  (cmd_fifo_full),
    .cmd_fifo_empty (cmd_fifo_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cyc = 0;
  int tx_cyc = 0;
  logic [7:0]  regs [256];
  logic [7:0]  bq [$];
  logic [15:0] wr_log [$];
  logic [7:0]  rd_log [$];
  logic [7:0]  tx_log [$];
  bit pend_pop = 1'b0;
  bit both_hi = 1'b0, addr_leak = 1'b0, saw_full = 1'b0, saw_stall = 1'b0;

  // The RX FIFO pops whatever byte_fifo_rd_en accepted at the preceding edge.
  always @(posedge clk) begin
    cyc++;
    pend_pop = byte_fifo_rd_en;
  end

  // Environment: register bank, RX byte FIFO and strobe monitors.
  always @(negedge clk) begin
    if (mem_write_en && mem_read_en) both_hi = 1'b1;
    if (!mem_write_en && !mem_read_en && mem_addr != 8'h00) addr_leak = 1'b1;
    if (cmd_fifo_full) saw_full = 1'b1;
    if (cmd_fifo_full && byte_fifo_valid && !byte_fifo_rd_en) saw_stall = 1'b1;
    if (mem_write_en) begin
      wr_log.push_back({mem_addr, mem_write_data});
      regs[mem_addr] = mem_write_data;
    end
    if (mem_read_en) begin
      rd_log.push_back(mem_addr);
      mem_read_data = regs[mem_addr];
      rd_cyc = cyc;
    end
    if (out_tx_en) begin
      tx_log.push_back(data_out_tx);
      tx_cyc = cyc;
    end
    if (pend_pop && bq.size() > 0) void'(bq.pop_front());
    pend_pop = 1'b0;
    byte_fifo_valid = (bq.size() > 0);
    byte_fifo_data  = (bq.size() > 0) ? bq[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bq.push_back(b);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_log.size() < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) regs[i] = 8'(i) ^ 8'h5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en",   {31'd0, mem_write_en},    32'd0);
    check("rst_rd_en",   {31'd0, mem_read_en},     32'd0);
    check("rst_tx_en",   {31'd0, out_tx_en},       32'd0);
    check("rst_pop",     {31'd0, byte_fifo_rd_en}, 32'd0);
    check("rst_addr",    {24'd0, mem_addr},        32'd0);
    check("rst_dout",    {24'd0, data_out_tx},     32'd0);
    check("rst_full",    {31'd0, cmd_fifo_full},   32'd0);
    check("rst_empty",   {31'd0, cmd_fifo_empty},  32'd1);
    rst = 1'b1;
    cycles(6);
    check("idle_wr",    wr_log.size(), 0);
    check("idle_rd",    rd_log.size(), 0);
    check("idle_tx",    tx_log.size(), 0);
    check("idle_empty", {31'd0, cmd_fifo_empty}, 32'd1);

    // Single write 0x10 <- 0xA5
    send(8'h57); send(8'h10); send(8'hA5);
    cycles(15);
    check("w_count",  wr_log.size(), 1);
    check("w_entry",  {16'd0, wr_log[0]}, 32'h10A5);
    check("w_no_rd",  rd_log.size(), 0);
    check("w_no_tx",  tx_log.size(), 0);

    // Read back 0x10
    send(8'h52); send(8'h10);
    wait_tx(1, 40);
    check("r_tx_count", tx_log.size(), 1);
    check("r_addr",     {24'd0, rd_log[0]}, 32'h10);
    check("r_data",     {24'd0, tx_log[0]}, 32'hA5);
    check("r_latency",  tx_cyc - rd_cyc, 2);
    cycles(3);
    check("r_hold",     {24'd0, data_out_tx}, 32'hA5);

    // Junk bytes dropped, then read 0x20
    send(8'hFF); send(8'h00); send(8'h52); send(8'h20);
    wait_tx(2, 60);
    check("j_tx_count", tx_log.size(), 2);
    check("j_rd_count", rd_log.size(), 2);
    check("j_addr",     {24'd0, rd_log[1]}, 32'h20);
    check("j_data",     {24'd0, tx_log[1]}, 32'h7A);
    check("j_wr_count", wr_log.size(), 1);

    // Flood with reads so the command FIFO fills
    for (int i = 0; i < 96; i++) begin
      send(8'h52);
      send(8'(8'h40 + i));
    end
    wait_tx(98, 3000);
    cycles(5);
    check("f_tx_count", tx_log.size(), 98);
    check("f_saw_full", {31'd0, saw_full},  32'd1);
    check("f_stall",    {31'd0, saw_stall}, 32'd1);
    bad = 0;
    for (int i = 0; i < 96; i++) begin
      if (rd_log[2+i] !== 8'(8'h40 + i)) bad++;
      if (tx_log[2+i] !== (8'(8'h40 + i) ^ 8'h5A)) bad++;
    end
    check("f_order", bad, 0);
    check("f_empty", {31'd0, cmd_fifo_empty}, 32'd1);

    // Reset in the middle of a write packet
    send(8'h57); send(8'h30);
    cycles(4);
    #2;
    rst = 1'b0;
    #1;
    check("mr_dout",  {24'd0, data_out_tx},     32'd0);
    check("mr_wr_en", {31'd0, mem_write_en},    32'd0);
    check("mr_rd_en", {31'd0, mem_read_en},     32'd0);
    check("mr_tx_en", {31'd0, out_tx_en},       32'd0);
    check("mr_pop",   {31'd0, byte_fifo_rd_en}, 32'd0);
    check("mr_empty", {31'd0, cmd_fifo_empty},  32'd1);
    cycles(2);
    rst = 1'b1;
    send(8'h52); send(8'h30);
    wait_tx(99, 60);
    cycles(10);
    check("pr_tx_count", tx_log.size(), 99);
    check("pr_addr",     {24'd0, rd_log[rd_log.size()-1]}, 32'h30);
    check("pr_data",     {24'd0, tx_log[tx_log.size()-1]}, 32'h6A);
    check("pr_no_write", wr_log.size(), 1);
    check("excl_strobe", {31'd0, both_hi},   32'd0);
    check("addr_idle0",  {31'd0, addr_leak}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_exec_pipeline.md
Name: cmd_exec_pipeline

Overview:
Command-execution core of the UART register-access system. It takes bytes from the UART RX byte FIFO and parses them into command packets. Packets are buffered in an internal command FIFO. A dispatcher then performs each command against the external register bank. Read results go out on a byte-wide TX response interface; writes return nothing.

Parameters:
DEPTH, 16, command FIFO entries (power of two).
ADDR_WIDTH, $clog2(DEPTH), command FIFO pointer width.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
byte_fifo_valid  in  1  RX byte FIFO non-empty; byte_fifo_data is valid (show-ahead).
byte_fifo_data  in  8  head byte of the RX FIFO.
byte_fifo_rd_en  out  1  pops one RX byte in the cycle it is high.
mem_addr  out  8  register address.
mem_write_en  out  1  register write strobe.
mem_write_data  out  8  register write data.
mem_read_en  out  1  register read strobe.
mem_read_data  in  8  register bank read data; valid the cycle after mem_read_en.
data_out_tx  out  8  read response byte.
out_tx_en  out  1  one-cycle strobe qualifying data_out_tx.
cmd_fifo_full  out  1  command FIFO full.
cmd_fifo_empty  out  1  command FIFO empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - All FSMs go to their initial state.
  - FIFO pointers and count clear.
  - Every output is 0, except cmd_fifo_empty=1.
  - Any partial packet or in-flight command is discarded.
- Packet format is 24 bits: opcode[23:16], addr[15:8], data[7:0].
  - Write opcode = 0x57 ('W').
  - Read opcode = 0x52 ('R').
- Parser FSM states: OP, ADDR, DATA, PUSH.
  - byte_fifo_rd_en = byte_fifo_valid AND state in {OP, ADDR, DATA} (combinational). The byte is captured at that edge.
  - OP: a byte of 0x57 or 0x52 latches the opcode and moves to ADDR. Any other byte is consumed and dropped; the FSM stays in OP.
  - ADDR: latches addr. A 'W' packet moves to DATA. An 'R' packet sets data=0x00 and moves to PUSH.
  - DATA: latches data and moves to PUSH.
  - PUSH: if the FIFO is not full, pulse the write enable for one cycle and move to OP. If full, hold in PUSH and consume no bytes; there is no packet loss.
- Command FIFO: DEPTH x 24 bits, circular buffer with pointer wrap, show-ahead read.
  - valid = !empty; rd_data = mem[rd_ptr] combinationally.
  - A write while full is ignored, even if a read occurs in the same cycle.
  - A read while empty is ignored.
  - A simultaneous read and write when neither full nor empty leaves the count unchanged.
  - full and empty are registered and consistent with the count.
- Dispatcher FSM states: IDLE, EXEC, READ_WAIT, RESP.
  - IDLE: when valid, assert the FIFO rd_en (combinational, one cycle), latch the packet, go to EXEC.
  - EXEC, write: mem_write_en=1 with mem_addr and mem_write_data from the packet for one cycle, then IDLE.
  - EXEC, read: mem_read_en=1 with mem_addr for one cycle, then READ_WAIT.
  - READ_WAIT: capture mem_read_data into data_out_tx, go to RESP.
  - RESP: out_tx_en=1 for one cycle, then IDLE.
  - data_out_tx holds its value until the next read response.
- Latency:
  - A write strobe occurs 1 cycle after valid is seen in IDLE.
  - out_tx_en occurs 3 cycles after valid is seen in IDLE.
  - Throughput: a write every 2 cycles, a read every 4 cycles.
- mem_write_en and mem_read_en are never high together. mem_addr is 0 outside EXEC.
- Parser and dispatcher run concurrently. The FIFO decouples them.

Test Plan:
1. Reset then idle → all outputs 0 except cmd_fifo_empty=1. After rst rises, no strobes occur with byte_fifo_valid=0.
2. Bytes 0x57,0x10,0xA5 → exactly one mem_write_en pulse with mem_addr=0x10, mem_write_data=0xA5. No out_tx_en.
3. Write 0x10←0xA5, then bytes 0x52,0x10 → mem_read_en pulse with mem_addr=0x10. Next, out_tx_en pulses once with data_out_tx=0xA5, 3 cycles after dispatch start.
4. Bytes 0xFF,0x00,0x52,0x20 → 0xFF and 0x00 are dropped, 0x00 being parsed in OP as an invalid opcode; a single read of 0x20 occurs.
5. Hold the dispatcher busy with back-to-back commands so the FIFO fills (16 packets) → cmd_fifo_full=1, the parser stalls in PUSH, and byte_fifo_rd_en=0. All 17+ commands eventually execute in order; none are lost.
6. Assert rst low mid-packet (after 0x57,0x30) → outputs clear immediately. After release, bytes 0x52,0x30 produce a read of 0x30; no write to 0x30 occurs.
